// File: rtl/light_conflict_monitor_if.sv
// rtl/light_conflict_monitor_if.sv - light buses from the controller and monitor status back
interface light_conflict_monitor_if;
  logic [2:0]  light_M1;
  logic [2:0]  light_S;
  logic [2:0]  light_MT;
  logic [2:0]  light_M2;
  logic        fault;
  logic [2:0]  fault_code;
  logic [3:0]  fault_src;
  logic        flash_en;
  logic [15:0] transitions;

  modport master (
    output light_M1, light_S, light_MT, light_M2,
    input  fault, fault_code, fault_src, flash_en, transitions
  );

  modport slave (
    input  light_M1, light_S, light_MT, light_M2,
    output fault, fault_code, fault_src, flash_en, transitions
  );
endinterface

// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - passive checker of the four light buses
// Latches the first encoding/conflict/sequence/yellow/stuck violation and requests flashing red.
module light_conflict_monitor #(
  parameter int MIN_YELLOW  = 3,
  parameter int STUCK_LIMIT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  light_conflict_monitor_if.slave bus
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [YW-1:0] MIN_Y     = YW'(MIN_YELLOW);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_LIMIT);

  localparam logic [2:0] C_R = 3'b100;
  localparam logic [2:0] C_Y = 3'b010;
  localparam logic [2:0] C_G = 3'b001;

  typedef enum logic [1:0] {INIT, MONITOR, FAULT} state_t;

  state_t          state;
  logic [2:0]      prev   [4];
  logic [YW-1:0]   ycnt   [4];
  logic [SW-1:0]   stuck_cnt;
  logic            fault_q;
  logic [2:0]      code_q;
  logic [3:0]      src_q;
  logic [15:0]     trans_q;

  // Index order matches fault_src bits: 0 M1, 1 S, 2 MT, 3 M2
  logic [2:0]      cur    [4];
  logic [YW-1:0]   ycnt_nx[4];
  logic [3:0]      valid, active, changed, illegal, legal, short_y;
  logic [3:0]      enc_src, conf_src;
  logic [2:0]      n_legal;
  logic [SW-1:0]   stuck_nx;
  logic [16:0]     trans_sum;
  logic [2:0]      chk_code;
  logic [3:0]      chk_src;

  assign cur[0] = bus.light_M1;
  assign cur[1] = bus.light_S;
  assign cur[2] = bus.light_MT;
  assign cur[3] = bus.light_M2;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid[i]   = (cur[i] == C_R) || (cur[i] == C_Y) || (cur[i] == C_G);
      active[i]  = valid[i] && (cur[i] != C_R);
      changed[i] = valid[i] && (cur[i] != prev[i]);
      illegal[i] = changed[i] && (((prev[i] == C_G) && (cur[i] == C_R)) ||
                                  ((prev[i] == C_R) && (cur[i] == C_Y)) ||
                                  ((prev[i] == C_Y) && (cur[i] == C_G)));
      legal[i]   = changed[i] && !illegal[i];
      short_y[i] = (prev[i] == C_Y) && (cur[i] == C_R) && (ycnt[i] < MIN_Y);
      if (cur[i] != C_Y)
        ycnt_nx[i] = '0;
      else if (prev[i] != C_Y)
        ycnt_nx[i] = YW'(1);
      else if (ycnt[i] == MIN_Y)
        ycnt_nx[i] = ycnt[i];
      else
        ycnt_nx[i] = ycnt[i] + YW'(1);
    end

    enc_src = ~valid;
    // M1 may share with M2 or MT; S shares with nobody; M2 and MT exclude each other
    conf_src[0] = active[1] && active[0];
    conf_src[1] = active[1] && (active[0] || active[2] || active[3]);
    conf_src[2] = active[2] && (active[1] || active[3]);
    conf_src[3] = active[3] && (active[1] || active[2]);

    n_legal   = {2'b00, legal[0]} + {2'b00, legal[1]} + {2'b00, legal[2]} + {2'b00, legal[3]};
    trans_sum = {1'b0, trans_q} + {14'b0, n_legal};
    stuck_nx  = stuck_cnt + SW'(1);

    chk_code = 3'd0;
    chk_src  = 4'b0000;
    if (|enc_src) begin
      chk_code = 3'd1;
      chk_src  = enc_src;
    end else if (|conf_src) begin
      chk_code = 3'd2;
      chk_src  = conf_src;
    end else if (state == MONITOR) begin
      if (|illegal) begin
        chk_code = 3'd3;
        chk_src  = illegal;
      end else if (|short_y) begin
        chk_code = 3'd4;
        chk_src  = short_y;
      end else if (!(|changed) && (stuck_nx == STUCK_MAX)) begin
        chk_code = 3'd5;
        chk_src  = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      stuck_cnt <= '0;
      fault_q   <= 1'b0;
      code_q    <= 3'd0;
      src_q     <= 4'b0000;
      trans_q   <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        prev[i] <= 3'b000;
        ycnt[i] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          stuck_cnt <= '0;
          for (int i = 0; i < 4; i++) begin
            prev[i] <= cur[i];
            ycnt[i] <= MIN_Y;
          end
          if (chk_code != 3'd0) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            code_q  <= chk_code;
            src_q   <= chk_src;
          end else begin
            state <= MONITOR;
          end
        end
        MONITOR: begin
          if (chk_code != 3'd0) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            code_q  <= chk_code;
            src_q   <= chk_src;
          end else begin
            for (int i = 0; i < 4; i++) begin
              prev[i] <= cur[i];
              ycnt[i] <= ycnt_nx[i];
            end
            stuck_cnt <= (|changed) ? '0 : stuck_nx;
            trans_q   <= trans_sum[16] ? 16'hFFFF : trans_sum[15:0];
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.fault       = fault_q;
  assign bus.flash_en    = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.fault_src   = src_q;
  assign bus.transitions = trans_q;

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
- Passive checker on the receiving end of the traffic-light controller's four 3-bit light buses.
- Samples light_M1, light_S, light_MT and light_M2 every clock and checks encoding, conflicting greens, colour sequence, minimum yellow time and stuck outputs.
- On the first violation it latches a fault code and the offending approaches, and asserts flash_en for the downstream flashing-red override.
- Sits beside the controller at the intersection top level.

Parameters:
MIN_YELLOW, 3, minimum consecutive cycles an approach must show yellow before red (>=1)
STUCK_LIMIT, 64, consecutive MONITOR cycles with no light change that raise a stuck fault (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
light_M1  input  3  main road dir 1 light, {red,yellow,green} one-hot (bit2=R, bit1=Y, bit0=G)
light_S  input  3  side road light, same encoding
light_MT  input  3  main turn light, same encoding
light_M2  input  3  main road dir 2 light, same encoding
fault  output  1  latched fault flag
fault_code  output  3  0 none, 1 ENCODING, 2 CONFLICT, 3 SEQUENCE, 4 SHORT_YELLOW, 5 STUCK
fault_src  output  4  approaches involved in the latched fault, bit0 M1, bit1 S, bit2 MT, bit3 M2
flash_en  output  1  equals fault, drives the flashing-red override
transitions  output  16  count of legal colour changes since reset, saturates at 16'hFFFF

Behaviour:
- Reset: one clock, synchronous active-high. While rst=1 at an edge:
  - fault=0, fault_code=0, fault_src=0, flash_en=0, transitions=0.
  - Stored previous samples and yellow and stuck counters cleared; FSM goes to INIT.
  - Reset applies mid-operation, including from FAULT.
- FSM states: INIT, MONITOR, FAULT.
- INIT (first edge after reset release):
  - Captures all four buses as prev.
  - Runs only the ENCODING and CONFLICT checks.
  - Preloads each yellow counter to MIN_YELLOW so a yellow present at startup cannot raise SHORT_YELLOW.
  - Goes to MONITOR, or to FAULT if a check fails.
- MONITOR, per edge, checks current inputs against prev:
  - ENCODING: a bus not exactly one-hot. src = every bad bus.
  - CONFLICT: "active" means G or Y. Allowed co-active pairs are only M1+M2 and M1+MT. S active together with any other active approach, or M2 and MT active together, is a conflict. src = every active approach that is part of a conflicting pair.
  - SEQUENCE: legal changes are R->G, G->Y, Y->R; unchanged is always legal. G->R, R->Y and Y->G are illegal. src = each approach making an illegal change.
  - SHORT_YELLOW: a Y->R change on an approach whose yellow counter < MIN_YELLOW. src = those approaches.
  - STUCK: if no bus changed this edge, the stuck counter increments, otherwise it clears to 0. When the counter reaches STUCK_LIMIT it raises STUCK with src=4'b1111.
- Yellow counter, per approach: set to 1 on entering Y; increments while Y holds, saturating at MIN_YELLOW. Width is $clog2(MIN_YELLOW+1).
- Priority when several checks fail on the same edge: ENCODING > CONFLICT > SEQUENCE > SHORT_YELLOW > STUCK. Only the winning code and its src are latched.
- Latency: the violating sample is taken at edge N; fault, fault_code, fault_src and flash_en are all valid immediately after edge N. The FSM moves to FAULT at the same edge.
- Legal changes:
  - Each legal colour change on each approach adds 1 to transitions, so up to 4 per edge. The sum saturates at 16'hFFFF.
  - An edge that raises a fault adds nothing.
- FAULT state:
  - Sticky until rst; all outputs hold.
  - prev, counters and transitions are frozen.
  - Inputs are ignored.
- Transitions are evaluated only on encoding-valid buses; an invalid bus never counts as a change.

Test Plan:
- Legal cycle, MIN_YELLOW=3:
  - Stimulus: start M1=M2=G, S=MT=R; M1 and M2 G->Y, hold Y 3 cycles, ->R; S R->G->Y(3)->R; MT R->G.
  - Required: fault=0 throughout; transitions=8.
- Conflict:
  - Stimulus: from M1=G, M2=R, MT=R, S=R, drive S=G.
  - Required: at that edge fault=1, fault_code=2, fault_src=4'b0011, flash_en=1.
  - Then drive S=R: outputs unchanged.
- Short yellow:
  - Stimulus: M2 G->Y, hold 2 cycles, ->R.
  - Required: fault_code=4, fault_src=4'b1000; transitions counts only the G->Y change.
- Sequence plus priority:
  - Stimulus: MT G->R.
  - Required: fault_code=3, fault_src=4'b0100.
  - After rst, in one sample drive S=3'b110 together with M2=G and MT=G.
  - Required: fault_code=1, fault_src=4'b0010 (encoding beats conflict).
- Stuck:
  - Stimulus: hold legal lights constant.
  - Required: fault=0 after 63 MONITOR edges; fault=1, fault_code=5, fault_src=4'b1111 at the 64th.
- Reset mid-fault:
  - Stimulus: assert rst for 1 cycle while in FAULT.
  - Required: all outputs 0 on the next edge; monitoring resumes through INIT with transitions=0.
